mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit of the 5-stage RV32I pipeline.
- Takes the M-stage address, store data, funct3 and memory-op strobes, and runs a req/ack handshake with data memory.
- Produces the aligned and extended load result ReadDataM, which feeds the M/W pipeline register.
- Stalls the pipeline (StallM) until the access completes or times out.

---
 rtl/lsu_pkg.sv | 57 +++++
 rtl/load_extend.sv | 31 +++
 rtl/mem_stage_lsu.sv | 145 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and store-side helpers for the memory-stage LSU.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Illegal size or an address not aligned to the access size.
  function automatic logic access_fault(input logic       is_load,
                                        input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic legal;
    logic bad_align;
    case (f3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = is_load;
      default:          legal = 1'b0;
    endcase
    bad_align = ((f3[1:0] == 2'b01) && off[0]) ||
                ((f3[1:0] == 2'b10) && (off != 2'b00));
    return (is_load | is_store) & (~legal | bad_align);
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [3:0] strb;
    case (f3)
      F3_B:    strb = 4'b0001 << off;
      F3_H:    strb = 4'b0011 << {off[1], 1'b0};
      F3_W:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Replicate the store operand across lanes so any strobe pattern picks it up.
  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{wd[7:0]}};
      F3_H:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign/zero extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic        [7:0]  byte_sel;
  logic        [15:0] half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    byte_s   = signed'(byte_sel);
    half_s   = signed'(half_sel);
    data     = rdata;
    case (funct3)
      F3_B:    data = 32'(byte_s);
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = 32'(half_s);
      F3_HU:   data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: one req/ack data-memory access at a time, with
// pipeline stall, misalignment detection and a bus timeout.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  lsu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          buserr_q, buserr_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;

  logic          op;
  logic          misalign;
  logic [31:0]   load_fmt;

  assign op       = MemReadM | MemWriteM;
  assign misalign = access_fault(MemReadM, MemWriteM, funct3M, ALUResultM[1:0]);

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (load_fmt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
      off_q    <= '0;
      f3_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
      off_q    <= off_d;
      f3_q     <= f3_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    buserr_d = buserr_q;
    off_d    = off_q;
    f3_d     = f3_q;
    case (state_q)
      IDLE: begin
        if (op && !misalign) begin
          state_d = BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = {ALUResultM[31:2], 2'b00};
          wstrb_d = MemWriteM ? store_strb(funct3M, ALUResultM[1:0]) : 4'b0000;
          wdata_d = store_data(funct3M, WriteDataM);
          off_d   = ALUResultM[1:0];
          f3_d    = funct3M;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // An ack in the timeout cycle still completes the access normally.
        if (mem_ack) begin
          state_d  = DONE;
          req_d    = 1'b0;
          buserr_d = 1'b0;
          if (!we_q) rdata_d = load_fmt;
        end else if (cnt_q >= CNT_LAST) begin
          state_d  = DONE;
          req_d    = 1'b0;
          buserr_d = 1'b1;
          rdata_d  = '0;
        end
      end
      DONE: begin
        state_d  = IDLE;
        buserr_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign StallM    = op & ~misalign & (state_q != DONE);
  assign MisalignM = misalign;
  assign ReadDataM = rdata_q;
  assign BusErrM   = buserr_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed and randomized bench for mem_stage_lsu against a byte-level access model.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd = 32'h0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, legality and alignment by arithmetic.
  function automatic int unsigned nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal_op(input bit ld, input logic [2:0] f3);
    if (ld) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return f3 inside {3'd0, 3'd1, 3'd2};
  endfunction

  function automatic bit model_mis(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] addr);
    if (!(ld || st)) return 1'b0;
    if (!legal_op(ld, f3)) return 1'b1;
    return (addr % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * (addr % 4));
    case (nbytes(f3))
      1: begin
        v = v & 32'hFF;
        if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end
      2: begin
        v = v & 32'hFFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned m;
    m = ((1 << nbytes(f3)) - 1) << (addr % 4);
    return m & 32'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int unsigned n;
    n = nbytes(f3);
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % n) +: 8];
    return r;
  endfunction

  // Entered and left at 1 time unit after a rising edge.
  task automatic access(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdata, input bit spur);
    bit misx;
    bit done;
    bit berr;
    int n;
    misx = model_mis(ld, st, f3, addr);
    MemReadM = ld; MemWriteM = st; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    mem_ack = 1'b0;
    #1;
    chk("misalign", MisalignM, misx);
    chk("stall_idle", StallM, (ld || st) && !misx);
    if (!(ld || st) || misx) begin
      @(posedge clk); #1;
      chk("noreq", mem_req, 0);
      chk("rd_hold", ReadDataM, exp_rd);
      MemReadM = 0; MemWriteM = 0;
      return;
    end
    @(posedge clk); #1;
    done = 0; berr = 0; n = 0;
    while (!done) begin
      n++;
      chk("req", mem_req, 1);
      chk("addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("we", mem_we, st);
      chk("strb", mem_wstrb, st ? model_strb(f3, addr) : 32'h0);
      if (st) chk("wdata", mem_wdata, model_wdata(f3, wd));
      chk("stall_busy", StallM, 1);
      mem_ack = (n == ack_at);
      mem_rdata = mem_ack ? rdata : $urandom;
      @(posedge clk); #1;
      if (n == ack_at) begin
        done = 1;
        if (ld) exp_rd = model_load(f3, addr, rdata);
      end else if (n == TO) begin
        done = 1; berr = 1; exp_rd = 0;
      end
    end
    chk("req_cycles", n, (ack_at <= TO) ? ack_at : TO);
    mem_ack = spur;
    mem_rdata = $urandom;
    #1;
    chk("stall_done", StallM, 0);
    chk("req_done", mem_req, 0);
    chk("buserr", BusErrM, berr);
    chk("rdata", ReadDataM, exp_rd);
    MemReadM = 0; MemWriteM = 0;
    @(posedge clk); #1;
    chk("buserr_clr", BusErrM, 0);
    chk("req_idle", mem_req, 0);
    chk("rd_after", ReadDataM, exp_rd);
    if (spur) begin
      @(posedge clk); #1;
      chk("spur_req", mem_req, 0);
      chk("spur_rd", ReadDataM, exp_rd);
    end
    mem_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    MemReadM = 0; MemWriteM = 0; funct3M = 0; ALUResultM = 0; WriteDataM = 0;
    mem_ack = 0; mem_rdata = 0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_strb", mem_wstrb, 0);
    chk("rst_rd", ReadDataM, 0);
    chk("rst_berr", BusErrM, 0);
    chk("rst_stall", StallM, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    access(1, 0, 3'b010, 32'h100, 0, 2, 32'hDEADBEEF, 0);
    access(1, 0, 3'b000, 32'h203, 0, 1, 32'h80FF_1234, 0);
    chk("lb", ReadDataM, 32'hFFFF_FF80);
    access(1, 0, 3'b100, 32'h203, 0, 3, 32'h80FF_1234, 0);
    chk("lbu", ReadDataM, 32'h0000_0080);
    access(0, 1, 3'b000, 32'h41, 32'h0000_00A5, 1, 0, 0);
    access(0, 1, 3'b001, 32'h42, 32'h0000_1234, 2, 0, 0);
    access(1, 0, 3'b010, 32'h102, 0, 1, 0, 0);
    access(1, 0, 3'b011, 32'h100, 0, 1, 0, 0);
    access(0, 1, 3'b100, 32'h100, 0, 1, 0, 0);
    access(1, 0, 3'b001, 32'h201, 0, 1, 0, 0);
    access(1, 0, 3'b101, 32'h402, 0, TO, 32'hC0DE_8001, 0);
    access(1, 0, 3'b010, 32'h500, 0, 99, 32'h1111_1111, 1);

    // Reset in the middle of a BUSY access.
    MemReadM = 1; funct3M = 3'b010; ALUResultM = 32'h300; mem_ack = 0;
    @(posedge clk); #1;
    chk("mid_req", mem_req, 1);
    reset = 1; MemReadM = 0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_stall", StallM, 0);
    mem_ack = 1; mem_rdata = 32'h55AA_55AA;
    exp_rd = 0;
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    chk("post_rst_req", mem_req, 0);
    chk("post_rst_rd", ReadDataM, 0);
    chk("post_rst_berr", BusErrM, 0);
    mem_ack = 0;
    access(1, 0, 3'b010, 32'h304, 0, 1, 32'h0BAD_F00D, 0);

    for (int i = 0; i < 60; i++) begin
      bit ld, st;
      int sel;
      sel = $urandom_range(0, 7);
      ld = (sel < 4);
      st = (sel >= 4) && (sel < 7);
      access(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(1, TO + 1), $urandom, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
